// File: rtl/datapath_pkg.sv
// Shared definitions for the bus datapath controller.
//   - Opcode encodings accepted on instr_op.
//   - Sequencer state encoding.
//   - Default datapath width and register count.
package datapath_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_e;

endpackage

// File: rtl/datapath_ctrl_idx_to_onehot.sv
// idx_to_onehot: decodes a register index plus an enable into a one-hot
// register select. Indices at or above NUM_REGS decode to all zeros.
// Ports:
//   idx_i    register index
//   en_i     decode enable; when low the output is all zeros
//   onehot_o one-hot select, NUM_REGS bits
module idx_to_onehot
  import datapath_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // Matching against each legal index only; out-of-range indices hit nothing.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = en_i && (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: instruction sequencer for the shared-bus register/ALU
// datapath. Accepts LOAD/MOV/ADD/SUB over a valid/ready handshake and
// produces the per-cycle datapath enables as Moore outputs.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   instr_valid/instr_ready handshake; ready only in IDLE
//   instr_op/rx/ry/data     instruction fields, latched on acceptance
//   ext_data, ext_data_en   latched immediate and its bus drive
//   reg_in_en, reg_out_en   one-hot register write / bus drive
//   alu_reg_en, alu_sel     A-register load, ALU add(0)/sub(1)
//   g_reg_en, alu_out_en    G-register load, G bus drive
//   busy, done, err         status: not idle, final step, rejected index
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [1:0]          instr_op,
  input  logic [IDX_W-1:0]    instr_rx,
  input  logic [IDX_W-1:0]    instr_ry,
  input  logic [DATA_W-1:0]   instr_data,
  output logic [DATA_W-1:0]   ext_data,
  output logic                ext_data_en,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic                alu_reg_en,
  output logic                alu_sel,
  output logic                g_reg_en,
  output logic                alu_out_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [IDX_W-1:0]    rx_q, rx_d;
  logic [IDX_W-1:0]    ry_q, ry_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic accept;
  logic rx_ok, ry_ok, bad_idx;
  logic in_en, out_en, out_use_ry;

  assign accept   = instr_valid && (state_q == ST_IDLE);
  assign ext_data = data_q;

  // Field latches: only written on the accepting edge, so the outputs never
  // depend on the live instruction inputs once a sequence has started.
  always_comb begin
    op_d   = op_q;
    rx_d   = rx_q;
    ry_d   = ry_q;
    data_d = data_q;
    if (accept) begin
      op_d   = instr_op;
      rx_d   = instr_rx;
      ry_d   = instr_ry;
      data_d = instr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      data_q  <= data_d;
    end
  end

  // Index range check. Only matters when NUM_REGS is not a power of two;
  // otherwise every encodable index matches and the check folds away.
  always_comb begin
    rx_ok = 1'b0;
    ry_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_q == IDX_W'(i)) rx_ok = 1'b1;
      if (ry_q == IDX_W'(i)) ry_ok = 1'b1;
    end
  end

  // LOAD never reads a register, so its ry field is don't-care.
  assign bad_idx = !rx_ok || ((op_q != OP_LOAD) && !ry_ok);

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    busy        = 1'b1;
    ext_data_en = 1'b0;
    alu_reg_en  = 1'b0;
    alu_sel     = 1'b0;
    g_reg_en    = 1'b0;
    alu_out_en  = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    in_en       = 1'b0;
    out_en      = 1'b0;
    out_use_ry  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (accept) state_d = ST_T1;
      end
      ST_T1: begin
        if (bad_idx) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          case (op_q)
            OP_LOAD: begin
              ext_data_en = 1'b1;
              in_en       = 1'b1;
              done        = 1'b1;
              state_d     = ST_IDLE;
            end
            OP_MOV: begin
              out_en     = 1'b1;
              out_use_ry = 1'b1;
              in_en      = 1'b1;
              done       = 1'b1;
              state_d    = ST_IDLE;
            end
            default: begin
              // ADD/SUB: A <- Rx
              out_en     = 1'b1;
              alu_reg_en = 1'b1;
              state_d    = ST_T2;
            end
          endcase
        end
      end
      ST_T2: begin
        // G <- A +/- Ry; op bit 0 distinguishes SUB from ADD
        out_en     = 1'b1;
        out_use_ry = 1'b1;
        g_reg_en   = 1'b1;
        alu_sel    = op_q[0];
        state_d    = ST_T3;
      end
      ST_T3: begin
        // Rx <- G
        alu_out_en = 1'b1;
        in_en      = 1'b1;
        done       = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  idx_to_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_in_dec (
    .idx_i    (rx_q),
    .en_i     (in_en),
    .onehot_o (reg_in_en)
  );

  idx_to_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_out_dec (
    .idx_i    (out_use_ry ? ry_q : rx_q),
    .en_i     (out_en),
    .onehot_o (reg_out_en)
  );

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: an 8-register and a 6-register instance share
// the same instruction stream; each has its own transaction-level model.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        instr_valid = 1'b0;
  logic [1:0]  instr_op = 2'b00;
  logic [2:0]  instr_rx = 3'd0;
  logic [2:0]  instr_ry = 3'd0;
  logic [15:0] instr_data = 16'h0;

  always #5 clk = ~clk;

  logic        rdy8, busy8, exen8, areg8, asel8, greg8, aout8, done8, err8;
  logic [15:0] exd8;
  logic [7:0]  in8, out8;
  logic        rdy6, busy6, exen6, areg6, asel6, greg6, aout6, done6, err6;
  logic [15:0] exd6;
  logic [5:0]  in6, out6;

  datapath_ctrl #(.DATA_W(16), .NUM_REGS(8)) dut8 (
    .clk(clk), .resetn(resetn), .instr_valid(instr_valid), .instr_ready(rdy8),
    .instr_op(instr_op), .instr_rx(instr_rx), .instr_ry(instr_ry),
    .instr_data(instr_data), .ext_data(exd8), .ext_data_en(exen8),
    .reg_in_en(in8), .reg_out_en(out8), .alu_reg_en(areg8), .alu_sel(asel8),
    .g_reg_en(greg8), .alu_out_en(aout8), .busy(busy8), .done(done8), .err(err8)
  );

  datapath_ctrl #(.DATA_W(16), .NUM_REGS(6)) dut6 (
    .clk(clk), .resetn(resetn), .instr_valid(instr_valid), .instr_ready(rdy6),
    .instr_op(instr_op), .instr_rx(instr_rx), .instr_ry(instr_ry),
    .instr_data(instr_data), .ext_data(exd6), .ext_data_en(exen6),
    .reg_in_en(in6), .reg_out_en(out6), .alu_reg_en(areg6), .alu_sel(asel6),
    .g_reg_en(greg6), .alu_out_en(aout6), .busy(busy6), .done(done6), .err(err6)
  );

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        ext_en;
    logic [15:0] in_en;
    logic [15:0] out_en;
    logic        alu_reg_en;
    logic        alu_sel;
    logic        g_en;
    logic        alu_out_en;
    logic        done;
    logic        err;
    logic [15:0] ext_data;
  } outs_t;

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  // Reference model: per DUT, a queue of the output records of the cycles
  // still to come for the instruction in flight; empty means idle.
  outs_t q8[$];
  outs_t q6[$];
  logic [15:0] last8 = 16'h0;
  logic [15:0] last6 = 16'h0;

  function automatic outs_t idle_rec(input logic [15:0] d);
    outs_t r;
    r = '0;
    r.ready = 1'b1;
    r.ext_data = d;
    return r;
  endfunction

  function automatic void push_rec(input int w, input outs_t r);
    if (w == 0) q8.push_back(r);
    else q6.push_back(r);
  endfunction

  function automatic void model_accept(input int w, input logic [1:0] op,
                                       input int rx, input int ry,
                                       input logic [15:0] d);
    int n;
    outs_t b, r;
    n = (w == 0) ? 8 : 6;
    b = '0;
    b.busy = 1'b1;
    b.ext_data = d;
    if (rx >= n || (op != 2'b00 && ry >= n)) begin
      r = b; r.err = 1'b1; push_rec(w, r);
    end else if (op == 2'b00) begin
      r = b; r.ext_en = 1'b1; r.in_en = 16'(1) << rx; r.done = 1'b1; push_rec(w, r);
    end else if (op == 2'b01) begin
      r = b; r.out_en = 16'(1) << ry; r.in_en = 16'(1) << rx; r.done = 1'b1; push_rec(w, r);
    end else begin
      r = b; r.out_en = 16'(1) << rx; r.alu_reg_en = 1'b1; push_rec(w, r);
      r = b; r.out_en = 16'(1) << ry; r.g_en = 1'b1; r.alu_sel = op[0]; push_rec(w, r);
      r = b; r.alu_out_en = 1'b1; r.in_en = 16'(1) << rx; r.done = 1'b1; push_rec(w, r);
    end
  endfunction

  function automatic outs_t act(input int w);
    outs_t r;
    if (w == 0) begin
      r = '{rdy8, busy8, exen8, 16'(in8), 16'(out8), areg8, asel8, greg8, aout8, done8, err8, exd8};
    end else begin
      r = '{rdy6, busy6, exen6, 16'(in6), 16'(out6), areg6, asel6, greg6, aout6, done6, err6, exd6};
    end
    return r;
  endfunction

  function automatic outs_t expected(input int w);
    if (w == 0) return (q8.size() > 0) ? q8[0] : idle_rec(last8);
    return (q6.size() > 0) ? q6[0] : idle_rec(last6);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic check_all();
    outs_t a, e;
    int drivers;
    for (int w = 0; w < 2; w++) begin
      a = act(w);
      e = expected(w);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s outputs dut%0d got=%h exp=%h", phase, (w == 0) ? 8 : 6, a, e);
      end
      drivers = int'(a.ext_en) + int'(a.alu_out_en) + $countones(a.out_en);
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("FAIL %s bus_invariant dut%0d drivers=%0d max=1", phase, (w == 0) ? 8 : 6, drivers);
      end
    end
  endtask

  task automatic model_edge();
    if (!resetn) begin
      q8.delete(); q6.delete();
      last8 = 16'h0; last6 = 16'h0;
    end else begin
      if (q8.size() > 0) void'(q8.pop_front());
      else if (instr_valid) begin
        model_accept(0, instr_op, int'(instr_rx), int'(instr_ry), instr_data);
        last8 = instr_data;
      end
      if (q6.size() > 0) void'(q6.pop_front());
      else if (instr_valid) begin
        model_accept(1, instr_op, int'(instr_rx), int'(instr_ry), instr_data);
        last6 = instr_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy8 && rdy6) && n < 20) begin
      tick();
      n++;
    end
    chk({phase, " idle_timeout"}, 64'(n < 20), 64'd1);
  endtask

  task automatic drive(input logic [1:0] op, input int rx, input int ry, input logic [15:0] d);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rx    = 3'(rx);
    instr_ry    = 3'(ry);
    instr_data  = d;
  endtask

  typedef struct {
    logic [1:0]  op;
    int          rx;
    int          ry;
    logic [15:0] data;
    logic [7:0]  t1_in;
    logic [7:0]  t1_out;
    logic        t1_ext;
    int          busy_cyc;
    logic        err6;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n;
    tbl[0] = '{2'b00, 0, 0, 16'h0004, 8'h01, 8'h00, 1'b1, 1, 1'b0};
    tbl[1] = '{2'b01, 1, 0, 16'h1111, 8'h02, 8'h01, 1'b0, 1, 1'b0};
    tbl[2] = '{2'b10, 0, 1, 16'h2222, 8'h00, 8'h01, 1'b0, 3, 1'b0};
    tbl[3] = '{2'b11, 3, 5, 16'h3333, 8'h00, 8'h08, 1'b0, 3, 1'b0};
    tbl[4] = '{2'b00, 7, 0, 16'hFFFF, 8'h80, 8'h00, 1'b1, 1, 1'b1};
    tbl[5] = '{2'b01, 1, 6, 16'h5555, 8'h02, 8'h40, 1'b0, 1, 1'b1};
    tbl[6] = '{2'b10, 2, 7, 16'h6666, 8'h00, 8'h04, 1'b0, 3, 1'b1};
    tbl[7] = '{2'b00, 5, 7, 16'h8001, 8'h20, 8'h00, 1'b1, 1, 1'b0};
    tbl[8] = '{2'b01, 4, 4, 16'h0000, 8'h10, 8'h10, 1'b0, 1, 1'b0};

    // Reset state, no clock edge involved
    #2;
    check_all();
    chk("reset ready8", 64'(rdy8), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Table-driven single instructions
    for (int i = 0; i < 9; i++) begin
      phase = $sformatf("vec%0d", i);
      wait_idle();
      drive(tbl[i].op, tbl[i].rx, tbl[i].ry, tbl[i].data);
      tick();
      instr_valid = 1'b0;
      chk({phase, " t1_in"}, 64'(in8), 64'(tbl[i].t1_in));
      chk({phase, " t1_out"}, 64'(out8), 64'(tbl[i].t1_out));
      chk({phase, " t1_ext_en"}, 64'(exen8), 64'(tbl[i].t1_ext));
      chk({phase, " err6"}, 64'(err6), 64'(tbl[i].err6));
      n = 0;
      while (!rdy8 && n < 10) begin
        tick();
        n++;
      end
      chk({phase, " busy_cycles"}, 64'(n), 64'(tbl[i].busy_cyc));
    end

    // ADD then SUB, step by step
    for (int s = 0; s < 2; s++) begin
      phase = (s == 0) ? "add_seq" : "sub_seq";
      wait_idle();
      drive((s == 0) ? 2'b10 : 2'b11, 0, 1, 16'h0005);
      tick();
      instr_valid = 1'b0;
      chk({phase, " T1 out"}, 64'(out8), 64'h01);
      chk({phase, " T1 alu_reg_en"}, 64'(areg8), 64'd1);
      tick();
      chk({phase, " T2 out"}, 64'(out8), 64'h02);
      chk({phase, " T2 g_en"}, 64'(greg8), 64'd1);
      chk({phase, " T2 alu_sel"}, 64'(asel8), 64'(s));
      tick();
      chk({phase, " T3 alu_out_en"}, 64'(aout8), 64'd1);
      chk({phase, " T3 in"}, 64'(in8), 64'h01);
      chk({phase, " T3 done"}, 64'(done8), 64'd1);
      tick();
      chk({phase, " back idle"}, 64'(rdy8), 64'd1);
    end

    // Valid held through an ADD: next instruction waits for IDLE
    phase = "busy_hs";
    wait_idle();
    drive(2'b10, 0, 1, 16'h0000);
    tick();
    drive(2'b00, 2, 0, 16'h0055);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("busy_hs ready T%0d", c + 1), 64'(rdy8), 64'd0);
      tick();
    end
    chk("busy_hs idle ready", 64'(rdy8), 64'd1);
    tick();
    instr_valid = 1'b0;
    chk("busy_hs load in", 64'(in8), 64'h04);
    chk("busy_hs load ext", 64'(exd8), 64'h0055);
    tick();
    tick();
    chk("busy_hs no repeat", 64'(in8), 64'h00);

    // Reset asserted in T2 of an ADD
    phase = "mid_reset";
    wait_idle();
    drive(2'b10, 3, 4, 16'h00AA);
    tick();
    instr_valid = 1'b0;
    tick();
    chk("mid_reset in T2", 64'(greg8), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_reset async out8", 64'(out8), 64'h00);
    chk("mid_reset async g_en", 64'(greg8), 64'd0);
    chk("mid_reset async ready", 64'(rdy8), 64'd1);
    chk("mid_reset async busy6", 64'(busy6), 64'd0);
    chk("mid_reset ext_data", 64'(exd8), 64'h0);
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) tick();

    // Illegal index on the 6-register instance
    phase = "illegal";
    wait_idle();
    drive(2'b01, 7, 0, 16'h0000);
    tick();
    instr_valid = 1'b0;
    chk("illegal err6", 64'(err6), 64'd1);
    chk("illegal in6", 64'(in6), 64'h0);
    chk("illegal out6", 64'(out6), 64'h0);
    tick();
    chk("illegal err6 pulse", 64'(err6), 64'd0);
    chk("illegal idle6", 64'(rdy6), 64'd1);

    // Randomised instruction stream
    phase = "random";
    for (int k = 0; k < 200; k++) begin
      wait_idle();
      n = int'($urandom_range(0, 2));
      for (int g = 0; g < n; g++) tick();
      drive(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
      tick();
      instr_valid = 1'b0;
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Parametrised control sequencer for the shared-bus register/ALU datapath. It accepts one instruction at a time over a valid/ready handshake (LOAD, MOV, ADD, SUB) and generates the per-cycle datapath enables (external data, register in/out, A register, G register, ALU output) that have so far been driven by hand-written stimulus. Register count and data width are parameters. It sits directly in front of `datapath`, and its outputs connect port-for-port to the datapath enables.

## Interface
Parameters:
- `DATA_W`, 16, datapath and immediate width.
- `NUM_REGS`, 8, number of general registers, 2..16.
- `IDX_W`, `$clog2(NUM_REGS)`, register index width (derived).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `instr_op`  in  2  opcode: 00 LOAD, 01 MOV, 10 ADD, 11 SUB.
- `instr_rx`  in  IDX_W  destination / first operand register.
- `instr_ry`  in  IDX_W  source / second operand register.
- `instr_data`  in  DATA_W  immediate for LOAD.
- `ext_data`  out  DATA_W  latched immediate, to the datapath external data input.
- `ext_data_en`  out  1  drive `ext_data` onto the bus.
- `reg_in_en`  out  NUM_REGS  one-hot register write enable.
- `reg_out_en`  out  NUM_REGS  one-hot register bus drive.
- `alu_reg_en`  out  1  load the A register from the bus.
- `alu_sel`  out  1  0 = add, 1 = subtract.
- `g_reg_en`  out  1  load the G register with the ALU result.
- `alu_out_en`  out  1  drive G onto the bus.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse during the final step of an instruction.
- `err`  out  1  one-cycle pulse when an instruction is rejected because an index is ≥ NUM_REGS.

## Operation
- States are IDLE, T1, T2 and T3.
- **Accept:** a handshake is accepted on an edge where `instr_valid` and `instr_ready` are both high.
  - On acceptance, op, rx, ry and data are latched into internal registers.
  - The next state is T1.
- **LOAD:** T1 asserts `ext_data_en` and `reg_in_en[rx]`, plus `done`. Next state is IDLE.
- **MOV:** T1 asserts `reg_out_en[ry]` and `reg_in_en[rx]`, plus `done`. Next state is IDLE.
  - rx == ry is legal and acts as a no-op write.
- **ADD/SUB:**
  - T1 asserts `reg_out_en[rx]` and `alu_reg_en` (A ← Rx).
  - T2 asserts `reg_out_en[ry]`, `g_reg_en`, and `alu_sel` = op[0] (G ← A ± Ry).
  - T3 asserts `alu_out_en`, `reg_in_en[rx]` and `done` (Rx ← G). Next state is IDLE.
- **Illegal index:** an accepted instruction with rx or ry ≥ NUM_REGS asserts no datapath enables.
  - `err` pulses in T1, then the state returns to IDLE.
  - This applies only when NUM_REGS is not a power of two. MOV and LOAD check only the indices they actually use.
- **Outputs:** all outputs are Moore outputs, decoded from the state and latched fields only. Changing inputs after acceptance has no effect.
- **Bus invariant:** in every cycle, at most one of `ext_data_en`, `alu_out_en` or any `reg_out_en` bit is high.
- **Arithmetic:** performed in the datapath, not in this block. `ext_data` is DATA_W bits and is never truncated.

## Timing
- **Reset:**
  - Asserting `resetn` low forces state to IDLE immediately, asynchronously.
  - All enables, `done`, `err` and `ext_data` go to 0, and the latched fields are cleared.
  - `instr_ready` is 1 and `busy` is 0.
- **Reset mid-instruction:** the instruction is abandoned with no further enables. It is not resumed after reset releases.
- **Latency from accept edge:**
  - LOAD and MOV take 1 cycle; the write commits on the second edge after acceptance.
  - ADD and SUB take 3 cycles.
- **Throughput:** at least one IDLE cycle separates instructions. Per instruction, LOAD and MOV take 2 cycles; ADD and SUB take 4.
- **Busy behaviour:** `instr_valid` while busy is ignored and nothing is queued. The source must hold its instruction until it sees `instr_ready`.

## Structure
- `datapath_pkg` holds:
  - opcode localparams (OP_LOAD, OP_MOV, OP_ADD, OP_SUB);
  - the state encoding;
  - default DATA_W and NUM_REGS.
- One sub-module, `idx_to_onehot` (parameter NUM_REGS), decodes an index plus an enable into a one-hot vector, or all zeros when the index is out of range. It is instantiated twice, once for in and once for out.
- The FSM and field latches live in `datapath_ctrl`.

## Test plan
Benches run with NUM_REGS=8 and DATA_W=16 unless stated otherwise.
- **LOAD:** LOAD R0, 0x0004 accepted at edge k → in cycle k+1, `ext_data`=0x0004, `ext_data_en`=1, `reg_in_en`=0x01, `done`=1; back in IDLE at k+2.
- **MOV:** MOV R1 ← R0 → one cycle with `reg_out_en`=0x01, `reg_in_en`=0x02; with the datapath attached, R1 reads 4.
- **ADD/SUB:** LOAD R0, 5, then ADD R0,R1 with R1=4 → T1: out=0x01 with `alu_reg_en`; T2: out=0x02 with `g_reg_en`, `alu_sel`=0; T3: `alu_out_en` with in=0x01; R0 becomes 9. SUB then gives R0 = 5.
- **Busy handshake:** hold `instr_valid` throughout an ADD → `instr_ready`=0 during T1–T3; the second instruction is accepted exactly at the edge leaving IDLE, with no duplicate execution.
- **Reset mid-instruction:** pull `resetn` low in T2 of ADD → all enables drop to 0 within the same cycle with no clock; after release, state is IDLE and G is not written back.
- **Illegal index:** with NUM_REGS=6, MOV R7 ← R0 → `err` pulses for one cycle and all enables stay 0; the bus invariant holds across a randomised 200-instruction run.
